// File: rtl/ase_umsg_scheduler.sv
// Per-slot UMsg sequencer (Idle/ChangeOccured/SendHint/Waiting/SendData) with round-robin RX0 arbitration.
// Optional macro ASE_UMSG_HINT_EN enables the SendHint path; when undefined only data responses are produced.
module ase_umsg_scheduler #(
    parameter int NUM_UMSG   = 8,
    parameter int TIMER_W    = 8,
    parameter int HINT_DELAY = 20,
    parameter int DATA_DELAY = 40,
    localparam int ID_W      = $clog2(NUM_UMSG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                umsg_wr_valid,
    input  logic [ID_W-1:0]     umsg_wr_id,
    input  logic [511:0]        umsg_wr_data,
    input  logic [NUM_UMSG-1:0] umsg_hint_en,
    input  logic                rx_ready,
    output logic                rx_valid,
    output logic [27:0]         rx_hdr,
    output logic [511:0]        rx_data,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHANGE,
        S_WAIT,
        S_DATA
`ifdef ASE_UMSG_HINT_EN
        , S_HINT
`endif
    } state_t;

    localparam logic [TIMER_W-1:0] DATA_LAST = TIMER_W'(DATA_DELAY - 1);
`ifdef ASE_UMSG_HINT_EN
    localparam logic [TIMER_W-1:0] HINT_LAST = TIMER_W'(HINT_DELAY - 1);
    logic [NUM_UMSG-1:0] r_hint_rdy;
`else
    logic w_unused_hint;
    assign w_unused_hint = ^umsg_hint_en;
`endif

    state_t              r_state [NUM_UMSG];
    logic [511:0]        r_data  [NUM_UMSG];
    logic [TIMER_W-1:0]  r_timer [NUM_UMSG];
    logic [ID_W-1:0]     r_ptr;

    logic [NUM_UMSG-1:0] w_wr_hit;
    logic [NUM_UMSG-1:0] w_req;
    logic [NUM_UMSG-1:0] w_req_hint;
    logic [NUM_UMSG-1:0] w_gnt;
    logic                w_gnt_vld;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_gnt_hint;
    logic                w_any_busy;
    logic [15:0]         w_mdata;
    int unsigned         w_idx;

    always_comb begin
        w_wr_hit   = '0;
        w_req      = '0;
        w_req_hint = '0;
        w_any_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_UMSG; i++) begin
            w_wr_hit[i] = umsg_wr_valid && (umsg_wr_id == ID_W'(i));
`ifdef ASE_UMSG_HINT_EN
            w_req_hint[i] = (r_state[i] == S_HINT) && r_hint_rdy[i];
`endif
            w_req[i] = w_req_hint[i] || (r_state[i] == S_DATA);
            if (r_state[i] != S_IDLE) begin
                w_any_busy = 1'b1;
            end
        end
    end

    // Round-robin search beginning at the slot after the last grant.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_gnt     = '0;
        w_idx     = 0;
        for (int unsigned k = 0; k < NUM_UMSG; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_UMSG) begin
                w_idx -= NUM_UMSG;
            end
            if (rx_ready && !w_gnt_vld && w_req[w_idx[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx[ID_W-1:0];
            end
        end
        if (w_gnt_vld) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
        w_gnt_hint           = w_req_hint[w_gnt_id];
        w_mdata              = '0;
        w_mdata[ID_W-1:0]    = w_gnt_id;
        w_mdata[12]          = w_gnt_hint;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_UMSG; i++) begin
                r_state[i] <= S_IDLE;
                r_data[i]  <= '0;
                r_timer[i] <= '0;
            end
`ifdef ASE_UMSG_HINT_EN
            r_hint_rdy <= '0;
`endif
            r_ptr    <= '0;
            rx_valid <= 1'b0;
            rx_hdr   <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_UMSG; i++) begin
                // Writes always land in the data register; only Idle/granted-data slots change state.
                if (w_wr_hit[i]) begin
                    r_data[i] <= umsg_wr_data;
                end
                case (r_state[i])
                    S_IDLE: begin
                        if (w_wr_hit[i]) begin
                            r_state[i] <= S_CHANGE;
                        end
                    end
                    S_CHANGE: begin
                        r_timer[i] <= '0;
`ifdef ASE_UMSG_HINT_EN
                        r_hint_rdy[i] <= 1'b0;
                        r_state[i]    <= umsg_hint_en[i] ? S_HINT : S_WAIT;
`else
                        r_state[i]    <= S_WAIT;
`endif
                    end
`ifdef ASE_UMSG_HINT_EN
                    S_HINT: begin
                        if (w_gnt[i]) begin
                            r_state[i]    <= S_WAIT;
                            r_timer[i]    <= '0;
                            r_hint_rdy[i] <= 1'b0;
                        end else if (r_timer[i] == HINT_LAST) begin
                            r_hint_rdy[i] <= 1'b1;
                        end else begin
                            r_timer[i] <= r_timer[i] + 1'b1;
                        end
                    end
`endif
                    S_WAIT: begin
                        if (r_timer[i] == DATA_LAST) begin
                            r_state[i] <= S_DATA;
                        end else begin
                            r_timer[i] <= r_timer[i] + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_gnt[i]) begin
                            r_state[i] <= w_wr_hit[i] ? S_CHANGE : S_IDLE;
                        end
                    end
                    default: r_state[i] <= S_IDLE;
                endcase
            end

            rx_valid <= w_gnt_vld;
            busy     <= w_any_busy;
            if (w_gnt_vld) begin
                rx_hdr  <= {8'h00, 4'hF, w_mdata};
                rx_data <= w_gnt_hint ? '0 : r_data[w_gnt_id];
                r_ptr   <= (w_gnt_id == ID_W'(NUM_UMSG - 1)) ? '0 : w_gnt_id + 1'b1;
            end else begin
                rx_hdr  <= '0;
                rx_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ase_umsg_scheduler.sv
// Scoreboard bench for ase_umsg_scheduler: directed writes, expected RX0 responses queued with their cycle.
module tb_ase_umsg_scheduler;

    localparam logic [511:0] PA5 = {64{8'hA5}};
    localparam logic [511:0] P0  = {64{8'h10}};
    localparam logic [511:0] P1  = {64{8'h11}};
    localparam logic [511:0] P2  = {64{8'h12}};
    localparam logic [511:0] P5  = {64{8'h15}};
    localparam logic [511:0] P0B = {64{8'h20}};
    localparam logic [511:0] D1  = {16{32'hD1D1_0001}};
    localparam logic [511:0] D2  = {16{32'hD2D2_0002}};
    localparam logic [511:0] D3  = {16{32'hD3D3_0003}};
    localparam logic [511:0] PR  = {64{8'hEE}};

    logic         clk           = 1'b0;
    logic         rst           = 1'b1;
    logic         umsg_wr_valid = 1'b0;
    logic [2:0]   umsg_wr_id    = '0;
    logic [511:0] umsg_wr_data  = '0;
    logic [7:0]   umsg_hint_en  = '0;
    logic         rx_ready      = 1'b0;
    logic         rx_valid;
    logic [27:0]  rx_hdr;
    logic [511:0] rx_data;
    logic         busy;

    ase_umsg_scheduler #(
        .NUM_UMSG  (8),
        .TIMER_W   (8),
        .HINT_DELAY(20),
        .DATA_DELAY(40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .umsg_wr_valid(umsg_wr_valid),
        .umsg_wr_id   (umsg_wr_id),
        .umsg_wr_data (umsg_wr_data),
        .umsg_hint_en (umsg_hint_en),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_hdr       (rx_hdr),
        .rx_data      (rx_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  cyc;
        logic [27:0]  hdr;
        logic [511:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc   = 0;
    int unsigned t0    = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] mkhdr(input bit is_hint, input int unsigned id);
        logic [15:0] m;
        m     = 16'(id);
        m[12] = is_hint;
        return {8'h00, 4'hF, m};
    endfunction

    // Monitor: every rx_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rx cyc=%0d hdr=%h data=%h, none expected", cyc - t0, rx_hdr, rx_data);
            end else begin
                mon_e = sb.pop_front();
                if ((cyc - t0) != mon_e.cyc || rx_hdr !== mon_e.hdr || rx_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL rx_resp got cyc=%0d hdr=%h data=%h want cyc=%0d hdr=%h data=%h",
                             cyc - t0, rx_hdr, rx_data, mon_e.cyc, mon_e.hdr, mon_e.data);
                end
            end
        end
    end

    task automatic at(input int unsigned n);
        while (cyc < t0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        umsg_wr_valid = 1'b0;
        rx_ready      = 1'b0;
        umsg_hint_en  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        t0  = cyc;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_rx(input int unsigned c, input bit is_hint, input int unsigned id,
                             input logic [511:0] d);
        exp_t e;
        e.cyc  = c;
        e.hdr  = mkhdr(is_hint, id);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wr(input int unsigned c, input int unsigned id, input logic [511:0] d);
        at(c);
        umsg_wr_valid = 1'b1;
        umsg_wr_id    = 3'(id);
        umsg_wr_data  = d;
        at(c + 1);
        umsg_wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset state and single data UMsg without hint.
        do_reset();
        chk("rst_rx_valid", 512'(rx_valid), '0);
        chk("rst_rx_hdr", 512'(rx_hdr), '0);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_busy", 512'(busy), '0);
        rx_ready = 1'b1;
        expect_rx(53, 1'b0, 3, PA5);
        wr(10, 3, PA5);
        at(53);
        chk("busy_held", 512'(busy), 512'(1));
        at(54);
        chk("busy_clear", 512'(busy), '0);
        at(70);
        chk("t1_drained", 512'(sb.size()), '0);

        // Hint enable on every slot.
        do_reset();
        rx_ready     = 1'b1;
        umsg_hint_en = '1;
`ifdef ASE_UMSG_HINT_EN
        expect_rx(33, 1'b1, 3, '0);
        expect_rx(74, 1'b0, 3, PA5);
`else
        expect_rx(53, 1'b0, 3, PA5);
`endif
        wr(10, 3, PA5);
        at(90);
        chk("t2_drained", 512'(sb.size()), '0);

        // Round-robin: 0,2,5 simultaneous; one grant; then 1 ahead of re-armed 0.
        do_reset();
        expect_rx(61, 1'b0, 0, P0);
        expect_rx(111, 1'b0, 1, P1);
        expect_rx(112, 1'b0, 2, P2);
        expect_rx(113, 1'b0, 5, P5);
        expect_rx(114, 1'b0, 0, P0B);
        wr(10, 0, P0);
        wr(11, 2, P2);
        wr(12, 5, P5);
        at(60);
        rx_ready = 1'b1;
        at(61);
        rx_ready = 1'b0;
        wr(61, 0, P0B);
        wr(62, 1, P1);
        at(110);
        rx_ready = 1'b1;
        at(125);
        chk("t3_drained", 512'(sb.size()), '0);

        // Coalescing: overwrite while waiting, then write on the grant cycle.
        do_reset();
        rx_ready = 1'b1;
        expect_rx(53, 1'b0, 4, D2);
        expect_rx(95, 1'b0, 4, D3);
        wr(10, 4, D1);
        wr(30, 4, D2);
        wr(52, 4, D3);
        at(110);
        chk("t4_drained", 512'(sb.size()), '0);
        chk("t4_busy", 512'(busy), '0);

        // Backpressure: rx_ready low 40..79.
        do_reset();
        rx_ready = 1'b1;
        expect_rx(81, 1'b0, 3, PA5);
        wr(10, 3, PA5);
        at(40);
        rx_ready = 1'b0;
        at(60);
        chk("t5_busy_wait", 512'(busy), 512'(1));
        at(80);
        rx_ready = 1'b1;
        at(100);
        chk("t5_drained", 512'(sb.size()), '0);

        // Reset mid-flight discards the pending UMsg; writes during reset are dropped.
        do_reset();
        rx_ready = 1'b1;
        wr(10, 3, PA5);
        at(40);
        rx_ready = 1'b0;
        at(60);
        chk("t6_busy_pre", 512'(busy), 512'(1));
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 512'(rx_valid), '0);
        chk("t6_rst_hdr", 512'(rx_hdr), '0);
        chk("t6_rst_data", rx_data, '0);
        chk("t6_rst_busy", 512'(busy), '0);
        at(62);
        umsg_wr_valid = 1'b1;
        umsg_wr_id    = 3'd3;
        umsg_wr_data  = PR;
        at(65);
        umsg_wr_valid = 1'b0;
        rst           = 1'b0;
        rx_ready      = 1'b1;
        at(130);
        chk("t6_busy_post", 512'(busy), '0);
        chk("t6_drained", 512'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ase_umsg_scheduler.md
# ase_umsg_scheduler

Per-slot UMsg controller and RX0 scheduler for the ASE CCI-P emulator. It accepts software UMsg writes into `NUM_UMSG` slots and runs each slot through the Idle → ChangeOccured → SendHint → Waiting → SendData sequence with programmable hint/data delays. Ready slots are arbitrated round-robin onto the RX0 channel as UMsg responses (resptype 4'hF). It sits between the DPI UMsg write path and the RX0 response mux, which grants it free cycles through `rx_ready`.

## Interface
- `NUM_UMSG`, 8: number of UMsg slots, 2..64; `ID_W = $clog2(NUM_UMSG)`.
- `TIMER_W`, 8: hint/data timer width (matches `UMSG_DELAY_TIMER_LOG2`).
- `HINT_DELAY`, 20: cycles in SendHint before the hint is eligible, 1..2^TIMER_W-1.
- `DATA_DELAY`, 40: cycles in Waiting before data is eligible, 1..2^TIMER_W-1.

Ports (clock and reset first):
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `umsg_wr_valid` in 1: one-cycle UMsg write strobe.
- `umsg_wr_id` in ID_W: target slot.
- `umsg_wr_data` in 512: cache-line payload.
- `umsg_hint_en` in NUM_UMSG: per-slot hint enable (level), sampled in ChangeOccured.
- `rx_ready` in 1: RX0 slot free this cycle.
- `rx_valid` out 1: UMsg response valid, exactly one cycle per grant.
- `rx_hdr` out 28: RxHdr_t.
- `rx_data` out 512: payload; zero for hints.
- `busy` out 1: any slot not Idle (registered).

## Operation
- Each slot has a state, a 512-bit data register, `TIMER_W` timers and a ready flag.
- **Idle**: on a write to this slot, latch data → ChangeOccured.
- **ChangeOccured** (1 cycle):
  - `umsg_hint_en[i]`=1 → SendHint, hint timer cleared.
  - `umsg_hint_en[i]`=0 → Waiting, data timer cleared.
- **SendHint**:
  - Timer increments each cycle; at `HINT_DELAY-1` the slot becomes hint-ready and the timer holds.
  - On grant → Waiting, data timer cleared.
- **Waiting**: timer increments; at `DATA_DELAY-1` → SendData.
- **SendData**: data-ready; on grant → Idle.
- Coalescing:
  - A write to a non-Idle slot overwrites its data register without changing state or timers. The latest data is sent.
  - A write to a slot in the same cycle it is granted data: the old data is sent, the new data is latched, and the slot goes to ChangeOccured instead of Idle.
- Writes with `umsg_wr_id >= NUM_UMSG` are ignored.
- Arbitration:
  - Single round-robin pointer over all hint-ready and data-ready slots.
  - Search starts at (last granted + 1); after reset the search starts at slot 0.
  - A grant occurs only when `rx_ready`=1; at most one grant per cycle.
  - When `rx_ready`=0, ready slots wait indefinitely.
- Response fields:
  - resptype=4'hF.
  - vc, poison, hitmiss, format, rsvd22, clnum = 0.
  - mdata[12] = 1 for a hint, 0 for data.
  - mdata[ID_W-1:0] = slot id; all other mdata bits 0.

## Timing
- Reset (asynchronous assert):
  - All slots Idle, timers 0, data registers 0, RR pointer at slot 0.
  - `rx_valid`=0, `rx_hdr`=0, `rx_data`=0, `busy`=0.
  - Pending UMsgs are discarded. Writes during reset are dropped.
- A write strobed at cycle t puts the slot in ChangeOccured at t+1 and in SendHint/Waiting at t+2.
- No hint:
  - SendData at t+2+DATA_DELAY.
  - Granted that cycle if `rx_ready`.
  - `rx_valid` at t+3+DATA_DELAY.
- With hint:
  - Hint eligible at t+2+HINT_DELAY; hint `rx_valid` at t+3+HINT_DELAY.
  - Data `rx_valid` at t+4+HINT_DELAY+DATA_DELAY (when `rx_ready` is always high).
- Grant to output latency is 1 cycle. All outputs are registered.
- `rx_valid` returns to 0 the cycle after each grant unless another grant occurred.

## Configuration
- `ASE_UMSG_HINT_EN`:
  - Defined: full behaviour as above.
  - Undefined:
    - SendHint state, hint timer and hint-ready logic are removed.
    - ChangeOccured always goes to Waiting.
    - `umsg_hint_en` is ignored.
    - mdata[12] is always 0.

## Test plan
- Write slot 3, data 0xA5.., hint_en=0, at cycle 10, `rx_ready`=1 → single `rx_valid` at cycle 53, mdata=0x0003, data 0xA5.., `busy` clears at 54.
- Same with hint_en[3]=1 → hint at 33 (mdata=0x1003, data 0); data at 74 (mdata=0x0003).
- Slots 0, 2, 5 become data-ready in the same cycle with `rx_ready`=1 → grants in order 0, 2, 5 on consecutive cycles. A later single ready slot 1 is granted before a re-armed slot 0.
- Write slot 4 with D1 at cycle 10 and D2 at cycle 30 → exactly one data response, payload D2, at cycle 53. A write coinciding with the grant cycle → old data sent and a second response follows.
- Hold `rx_ready`=0 from cycle 40 to 80 for slot 3 written at cycle 10 → `rx_valid` at cycle 81. Assert `rst` at cycle 60 instead → outputs 0 immediately, no response ever issued.
- Build without `ASE_UMSG_HINT_EN`, hint_en all 1 → no hints; data at t+3+DATA_DELAY with mdata[12]=0.
